// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the manual/scan channel selector.
package mux_scan_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_mux.sv
// Combinational N_CH:1 selector of W-bit channels; out-of-range index yields zero.
module chan_mux #(
    parameter int N_CH  = 7,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] din,
    input  logic [SEL_W-1:0]  idx,
    output logic [W-1:0]      dout
);

    always_comb begin
        // NOTE: default before the loop so every path assigns dout (no latch).
        dout = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) dout = din[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Presents one manually selected channel, or scans all channels in order,
// through a valid/ready output register.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 7,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] din,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              start,
    input  logic              out_ready,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  ch_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           state;
    logic             mode_q;
    logic [SEL_W-1:0] load_idx;
    logic [W-1:0]     mux_dout;
    logic             last;

    // The next channel to load: the request's first channel in IDLE, else the successor.
    always_comb begin
        load_idx = ch_out + SEL_W'(1);
        if (state == IDLE) load_idx = (mode == MODE_SCAN) ? '0 : sel;
    end

    assign last = (mode_q == MODE_MANUAL) || (ch_out == SEL_W'(N_CH - 1));
    assign busy = (state != IDLE);

    chan_mux #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) u_chan_mux (
        .din  (din),
        .idx  (load_idx),
        .dout (mux_dout)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_MANUAL;
            y         <= '0;
            ch_out    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_SCAN || int'(sel) < N_CH) begin
                            mode_q    <= mode;
                            y         <= mux_dout;
                            ch_out    <= load_idx;
                            out_valid <= 1'b1;
                            state     <= PRESENT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            y      <= mux_dout;
                            ch_out <= load_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel: directed scenarios plus random traffic
// compared against a queue-based transaction model.
module tb_mux_scan_sel;

    localparam int N_CH  = 7;
    localparam int W     = 1;
    localparam int SEL_W = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH*W-1:0] din;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic              start;
    logic              out_ready;
    logic [W-1:0]      y;
    logic [SEL_W-1:0]  ch_out;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of channels still owed to downstream; front is the one presented.
    int           m_q[$];
    bit           m_valid;
    bit           m_done;
    bit           m_err;
    logic [W-1:0] m_y;
    int           m_ch;

    mux_scan_sel #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .mode      (mode),
        .sel       (sel),
        .start     (start),
        .out_ready (out_ready),
        .y         (y),
        .ch_out    (ch_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_y     = '0;
        m_ch    = 0;
    endfunction

    function automatic void model_present();
        m_valid = 1'b1;
        m_ch    = m_q[0];
        m_y     = din[m_ch*W +: W];
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_valid) begin
            if (start) begin
                if (mode) begin
                    for (int k = 0; k < N_CH; k++) m_q.push_back(k);
                end else if (int'(sel) < N_CH) begin
                    m_q.push_back(int'(sel));
                end else begin
                    m_err = 1'b1;
                end
                if (m_q.size() > 0) model_present();
            end
        end else if (out_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end else begin
                model_present();
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".busy"},      32'(busy),      32'(m_valid));
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".err"},       32'(err),       32'(m_err));
        check({tag, ".y"},         32'(y),         32'(m_y));
        check({tag, ".ch_out"},    32'(ch_out),    32'(m_ch));
        check({tag, ".err_done_excl"}, 32'(err & done), 32'd0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".y"},         32'(y),         32'd0);
        check({tag, ".ch_out"},    32'(ch_out),    32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".err"},       32'(err),       32'd0);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        out_ready = 1'b1;
        start     = 1'b0;
        while (out_valid && guard < 20) begin
            cycle(tag);
            guard++;
        end
        check({tag, ".drain_timeout"}, 32'(out_valid), 32'd0);
        cycle(tag);
    endtask

    initial begin
        logic [N_CH-1:0] pattern;
        int cnt_x;
        int cnt_d;
        pattern   = 7'b1101010;
        din       = pattern;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Manual select of channel 3.
        mode = 1'b0; sel = 3'd3; start = 1'b1; out_ready = 1'b1;
        cycle("man3");
        check("man3.y_const", 32'(y), 32'd1);
        check("man3.ch_const", 32'(ch_out), 32'd3);
        check("man3.valid_const", 32'(out_valid), 32'd1);
        start = 1'b0; sel = 3'd0;
        cycle("man3_done");
        check("man3.done_const", 32'(done), 32'd1);

        // Full scan with out_ready held high.
        mode = 1'b1; start = 1'b1;
        cycle("scan");
        start = 1'b0; mode = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("scan.ch%0d", k), 32'(ch_out), 32'(k));
            check($sformatf("scan.y%0d", k), 32'(y), 32'(pattern[k]));
            check($sformatf("scan.valid%0d", k), 32'(out_valid), 32'd1);
            cycle("scan");
        end
        check("scan.done_const", 32'(done), 32'd1);
        cycle("scan_post");
        check("scan.done_once", 32'(done), 32'd0);

        // Illegal manual select.
        mode = 1'b0; sel = 3'd7; start = 1'b1;
        cycle("illegal");
        check("illegal.err_const", 32'(err), 32'd1);
        check("illegal.valid_const", 32'(out_valid), 32'd0);
        check("illegal.busy_const", 32'(busy), 32'd0);
        start = 1'b0;
        cycle("illegal_post");
        check("illegal.err_pulse", 32'(err), 32'd0);

        // Back-pressure at channel 2.
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        cycle("stall");
        start = 1'b0;
        cycle("stall");
        cycle("stall");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall_hold");
            check("stall.ch_hold", 32'(ch_out), 32'd2);
            check("stall.y_hold", 32'(y), 32'd0);
        end
        out_ready = 1'b1;
        cycle("stall_rel");
        check("stall.ch_rel", 32'(ch_out), 32'd3);
        check("stall.y_rel", 32'(y), 32'd1);
        drain("stall_drain");

        // Reset in the middle of a scan, then a manual request right after release.
        mode = 1'b1; start = 1'b1;
        cycle("rst_scan");
        start = 1'b0;
        repeat (4) cycle("rst_scan");
        check("rst_scan.ch_before", 32'(ch_out), 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0; sel = 3'd6; start = 1'b1;
        cycle("rst_after");
        check("rst_after.y_const", 32'(y), 32'd1);
        check("rst_after.ch_const", 32'(ch_out), 32'd6);
        start = 1'b0;
        cycle("rst_after_done");

        // Start pulsed while a scan is in progress is ignored.
        mode = 1'b1; start = 1'b1; out_ready = 1'b1;
        cycle("busy_start");
        cnt_x = 0;
        cnt_d = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 2 || i == 3);
            if (out_valid && out_ready) cnt_x++;
            cycle("busy_start");
            if (done) cnt_d++;
        end
        check("busy_start.transfers", 32'(cnt_x), 32'd7);
        check("busy_start.dones", 32'(cnt_d), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            din       = N_CH'($urandom);
            mode      = 1'($urandom);
            sel       = SEL_W'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle("rand");
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
